// File: rtl/hpdcache_repl_sched.sv
// Replacement scheduler: round-robin arbitration of victim requests, directory read,
// one replacement strobe into the victim selector, and hit-driven PLRU update forwarding.
module hpdcache_repl_sched #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned SETS = 64,
    parameter int unsigned WAYS = 4,
    localparam int unsigned SETW = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*SETW-1:0] req_set_i,
    input  logic [NREQ-1:0]      req_updt_plru_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [WAYS-1:0]      rsp_way_o,

    output logic                 dir_rd_o,
    output logic [SETW-1:0]      dir_rd_set_o,
    input  logic                 dir_gnt_i,
    input  logic [WAYS-1:0]      dir_valid_i,

    input  logic                 hit_updt_i,
    output logic                 hit_ready_o,
    input  logic [SETW-1:0]      hit_set_i,
    input  logic [WAYS-1:0]      hit_way_i,

    output logic                 updt_o,
    output logic [SETW-1:0]      updt_set_o,
    output logic [WAYS-1:0]      updt_way_o,
    output logic                 repl_o,
    output logic [SETW-1:0]      repl_set_o,
    output logic [WAYS-1:0]      repl_dir_valid_o,
    output logic                 repl_updt_o,
    input  logic [WAYS-1:0]      victim_way_i,

    output logic                 busy_o
);

    typedef enum logic [2:0] {IDLE, DIR_RD, DIR_WAIT, SEL, RESP} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q;
    logic [SETW-1:0] set_q;
    logic [IDW-1:0]  id_q;
    logic            updt_q;
    logic [WAYS-1:0] dir_valid_q;
    logic [WAYS-1:0] way_q;
    logic            buf_valid_q;
    logic [SETW-1:0] buf_set_q;
    logic [WAYS-1:0] buf_way_q;

    logic            found;
    logic [IDW-1:0]  winner;
    logic [SETW-1:0] win_set;
    logic            win_updt;
    logic            accept;
    logic            conflict;

    // Two passes give a wrapping search: first from the pointer upward, then from 0.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_set  = '0;
        win_updt = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid_i[i] && (i >= int'(ptr_q))) begin
                found    = 1'b1;
                winner   = IDW'(i);
                win_set  = req_set_i[i*SETW +: SETW];
                win_updt = req_updt_plru_i[i];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid_i[i]) begin
                found    = 1'b1;
                winner   = IDW'(i);
                win_set  = req_set_i[i*SETW +: SETW];
                win_updt = req_updt_plru_i[i];
            end
        end
    end

    assign accept      = (state_q == IDLE) && found && rst_ni;
    assign req_ready_o = accept ? (NREQ'(1) << winner) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = DIR_RD;
            DIR_RD:   if (dir_gnt_i) state_d = DIR_WAIT;
            DIR_WAIT: state_d = SEL;
            SEL:      state_d = RESP;
            RESP:     if (rsp_ready_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            set_q       <= '0;
            id_q        <= '0;
            updt_q      <= 1'b0;
            dir_valid_q <= '0;
            way_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q  <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                set_q  <= win_set;
                id_q   <= winner;
                updt_q <= win_updt;
            end
            if (state_q == DIR_WAIT) dir_valid_q <= dir_valid_i;
            if (state_q == SEL)      way_q       <= victim_way_i;
        end
    end

    assign busy_o           = (state_q != IDLE);
    assign dir_rd_o         = (state_q == DIR_RD);
    assign dir_rd_set_o     = dir_rd_o ? set_q : '0;
    assign repl_o           = (state_q == SEL);
    assign repl_set_o       = repl_o ? set_q : '0;
    assign repl_dir_valid_o = repl_o ? dir_valid_q : '0;
    assign repl_updt_o      = repl_o & updt_q;
    assign rsp_valid_o      = (state_q == RESP);
    assign rsp_id_o         = rsp_valid_o ? id_q : '0;
    assign rsp_way_o        = !rsp_valid_o ? '0 : ((WAYS == 1) ? WAYS'(1) : way_q);

    // A hit colliding with a PLRU-updating replacement is delayed one cycle so the
    // victim selector never sees two updates to the same set in one cycle.
    assign hit_ready_o = ~buf_valid_q;
    assign conflict    = hit_updt_i & hit_ready_o & repl_o & repl_updt_o & (hit_set_i == repl_set_o);

    always_comb begin
        updt_o     = 1'b0;
        updt_set_o = '0;
        updt_way_o = '0;
        if (buf_valid_q) begin
            updt_o     = 1'b1;
            updt_set_o = buf_set_q;
            updt_way_o = buf_way_q;
        end else if (hit_updt_i && !conflict && rst_ni) begin
            updt_o     = 1'b1;
            updt_set_o = hit_set_i;
            updt_way_o = hit_way_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            buf_set_q   <= '0;
            buf_way_q   <= '0;
        end else if (conflict) begin
            buf_valid_q <= 1'b1;
            buf_set_q   <= hit_set_i;
            buf_way_q   <= hit_way_i;
        end else if (buf_valid_q) begin
            buf_valid_q <= 1'b0;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) rsp_valid_o |-> $onehot(rsp_way_o));
    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     (dir_rd_o && !dir_gnt_i) |=> $stable(dir_rd_set_o));

endmodule

// File: tb/tb_hpdcache_repl_sched.sv
// Directed bench for hpdcache_repl_sched: scripted transactions with hand-computed
// service order, latency, directory/response backpressure, hit conflicts and reset.
module tb_hpdcache_repl_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [11:0] req_set_i;
    logic [1:0]  req_updt_plru_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [0:0]  rsp_id_o;
    logic [3:0]  rsp_way_o;
    logic        dir_rd_o;
    logic [5:0]  dir_rd_set_o;
    logic        dir_gnt_i;
    logic [3:0]  dir_valid_i;
    logic        hit_updt_i;
    logic        hit_ready_o;
    logic [5:0]  hit_set_i;
    logic [3:0]  hit_way_i;
    logic        updt_o;
    logic [5:0]  updt_set_o;
    logic [3:0]  updt_way_o;
    logic        repl_o;
    logic [5:0]  repl_set_o;
    logic [3:0]  repl_dir_valid_o;
    logic        repl_updt_o;
    logic [3:0]  victim_way_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    hpdcache_repl_sched #(.NREQ(2), .SETS(64), .WAYS(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_set_i(req_set_i),
        .req_updt_plru_i(req_updt_plru_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_way_o(rsp_way_o),
        .dir_rd_o(dir_rd_o), .dir_rd_set_o(dir_rd_set_o), .dir_gnt_i(dir_gnt_i),
        .dir_valid_i(dir_valid_i),
        .hit_updt_i(hit_updt_i), .hit_ready_o(hit_ready_o), .hit_set_i(hit_set_i),
        .hit_way_i(hit_way_i),
        .updt_o(updt_o), .updt_set_o(updt_set_o), .updt_way_o(updt_way_o),
        .repl_o(repl_o), .repl_set_o(repl_set_o), .repl_dir_valid_o(repl_dir_valid_o),
        .repl_updt_o(repl_updt_o), .victim_way_i(victim_way_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " busy"},      32'(busy_o),      32'd0);
        checkOutput({tag, " dir_rd"},    32'(dir_rd_o),    32'd0);
        checkOutput({tag, " repl"},      32'(repl_o),      32'd0);
        checkOutput({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        checkOutput({tag, " req_ready"}, 32'(req_ready_o), 32'd0);
        checkOutput({tag, " updt"},      32'(updt_o),      32'd0);
        checkOutput({tag, " hit_ready"}, 32'(hit_ready_o), 32'd1);
    endtask

    // One full transaction, entered and left at posedge+1 with the DUT in IDLE.
    task automatic applyStimulus(input string tag, input logic [1:0] mask,
                                 input logic [5:0] set0, input logic [5:0] set1, input logic updt,
                                 input int gnt_wait, input int rsp_wait,
                                 input logic [3:0] dvalid, input logic [3:0] victim, input int exp_id,
                                 input logic hit_en, input logic [5:0] hit_set,
                                 input logic [3:0] hit_way, input logic exp_conflict);
        logic [1:0] onehot;
        logic [5:0] exp_set;
        onehot  = 2'b01 << exp_id;
        exp_set = (exp_id == 1) ? set1 : set0;

        req_set_i       = {set1, set0};
        req_updt_plru_i = {updt, updt};
        req_valid_i     = mask;
        #1;
        checkOutput({tag, " req_ready"}, 32'(req_ready_o), 32'(onehot));
        tick();
        req_valid_i = mask & ~onehot;

        for (int w = 0; w <= gnt_wait; w++) begin
            dir_gnt_i = (w == gnt_wait);
            #1;
            checkOutput({tag, " dir_rd"},     32'(dir_rd_o),     32'd1);
            checkOutput({tag, " dir_rd_set"}, 32'(dir_rd_set_o), 32'(exp_set));
            checkOutput({tag, " no_repl"},    32'(repl_o),       32'd0);
            tick();
        end
        dir_gnt_i   = 1'b0;
        dir_valid_i = dvalid;
        #1;
        checkOutput({tag, " wait_no_repl"}, 32'(repl_o), 32'd0);
        tick();
        dir_valid_i = 4'b0000;

        victim_way_i = victim;
        hit_updt_i   = hit_en;
        hit_set_i    = hit_set;
        hit_way_i    = hit_way;
        #1;
        checkOutput({tag, " repl"},           32'(repl_o),           32'd1);
        checkOutput({tag, " repl_set"},       32'(repl_set_o),       32'(exp_set));
        checkOutput({tag, " repl_dir_valid"}, 32'(repl_dir_valid_o), 32'(dvalid));
        checkOutput({tag, " repl_updt"},      32'(repl_updt_o),      32'(updt));
        if (hit_en) begin
            checkOutput({tag, " sel_updt"}, 32'(updt_o), 32'(!exp_conflict));
            if (!exp_conflict) begin
                checkOutput({tag, " sel_updt_set"}, 32'(updt_set_o), 32'(hit_set));
                checkOutput({tag, " sel_updt_way"}, 32'(updt_way_o), 32'(hit_way));
            end
        end
        tick();
        victim_way_i = 4'b0000;
        hit_updt_i   = 1'b0;

        for (int r = 0; r <= rsp_wait; r++) begin
            rsp_ready_i = (r == rsp_wait);
            #1;
            checkOutput({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'd1);
            checkOutput({tag, " rsp_id"},    32'(rsp_id_o),    32'(exp_id));
            checkOutput({tag, " rsp_way"},   32'(rsp_way_o),   32'(victim));
            checkOutput({tag, " busy_ready"}, 32'(req_ready_o), 32'd0);
            if (r == 0 && hit_en) begin
                checkOutput({tag, " buf_hit_ready"}, 32'(hit_ready_o), 32'(!exp_conflict));
                checkOutput({tag, " buf_updt"},      32'(updt_o),      32'(exp_conflict));
                if (exp_conflict) begin
                    checkOutput({tag, " buf_updt_set"}, 32'(updt_set_o), 32'(hit_set));
                    checkOutput({tag, " buf_updt_way"}, 32'(updt_way_o), 32'(hit_way));
                end
            end
            tick();
        end
        rsp_ready_i = 1'b0;
        req_valid_i = 2'b00;
        #1;
        checkIdleOutputs({tag, " end"});
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = '0; req_set_i = '0; req_updt_plru_i = '0;
        rsp_ready_i = 1'b0; dir_gnt_i = 1'b0; dir_valid_i = '0;
        hit_updt_i = 1'b0; hit_set_i = '0; hit_way_i = '0; victim_way_i = '0;
        #12;
        checkIdleOutputs("reset");
        tick();
        rst_ni = 1'b1;
        tick();

        // Round-robin from pointer 0 with both requesters pending: 0,1,0,1.
        applyStimulus("rr0", 2'b11, 6'd10, 6'd20, 1'b1, 0, 0, 4'b1111, 4'b0001, 0, 1'b0, 6'd0, 4'd0, 1'b0);
        applyStimulus("rr1", 2'b11, 6'd10, 6'd20, 1'b1, 0, 0, 4'b1111, 4'b0010, 1, 1'b0, 6'd0, 4'd0, 1'b0);
        applyStimulus("rr2", 2'b11, 6'd10, 6'd20, 1'b1, 0, 0, 4'b1111, 4'b0100, 0, 1'b0, 6'd0, 4'd0, 1'b0);
        applyStimulus("rr3", 2'b11, 6'd10, 6'd20, 1'b1, 0, 0, 4'b1111, 4'b1000, 1, 1'b0, 6'd0, 4'd0, 1'b0);

        applyStimulus("single", 2'b01, 6'd5, 6'd0, 1'b1, 0, 0, 4'b0111, 4'b1000, 0, 1'b0, 6'd0, 4'd0, 1'b0);
        // Pointer is 1 here, so requester 0 is found only by wrapping.
        applyStimulus("wrap", 2'b01, 6'd3, 6'd0, 1'b1, 0, 0, 4'b0011, 4'b0001, 0, 1'b0, 6'd0, 4'd0, 1'b0);
        applyStimulus("dir_bp", 2'b10, 6'd0, 6'd7, 1'b1, 3, 0, 4'b1111, 4'b0100, 1, 1'b0, 6'd0, 4'd0, 1'b0);
        applyStimulus("rsp_bp", 2'b01, 6'd12, 6'd0, 1'b0, 0, 5, 4'b1010, 4'b0010, 0, 1'b0, 6'd0, 4'd0, 1'b0);

        applyStimulus("hit_same", 2'b10, 6'd0, 6'd5, 1'b1, 0, 0, 4'b1111, 4'b0001, 1, 1'b1, 6'd5, 4'b0010, 1'b1);
        applyStimulus("hit_diff", 2'b01, 6'd5, 6'd0, 1'b1, 0, 0, 4'b1111, 4'b0100, 0, 1'b1, 6'd9, 4'b0100, 1'b0);
        applyStimulus("hit_noupd", 2'b10, 6'd0, 6'd5, 1'b0, 0, 0, 4'b1111, 4'b1000, 1, 1'b1, 6'd5, 4'b1000, 1'b0);

        // Reset in DIR_WAIT drops the request and rewinds the pointer to 0.
        req_set_i   = {6'd0, 6'd33};
        req_valid_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        dir_gnt_i   = 1'b1;
        tick();
        dir_gnt_i = 1'b0;
        #1;
        checkOutput("pre_reset busy", 32'(busy_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        checkIdleOutputs("async_reset");
        tick();
        rst_ni = 1'b1;
        applyStimulus("post_reset", 2'b11, 6'd40, 6'd41, 1'b1, 0, 0, 4'b0101, 4'b0100, 0, 1'b0, 6'd0, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
